// File: rtl/video_pattern_gen_if.sv
// Video output bundle of the pattern generator: frame-valid, line-valid,
// pixel data and the end-of-frame pulse, as seen by the filter chain input.
`timescale 1ns/1ps
interface video_pattern_gen_if #(
  parameter int DW = 8
);
  logic          vvalid;
  logic          hvalid;
  logic [DW-1:0] dout;
  logic          frame_done;

  modport master (output vvalid, output hvalid, output dout, output frame_done);
  modport slave  (input  vvalid, input  hvalid, input  dout, input  frame_done);
endinterface

// File: rtl/video_pattern_gen.sv
// Programmable raster timing source with a selectable test pattern.
// A frame is VFP blank lines, one LEAD line (vvalid only), ACTIVE lines and
// VBP blank lines. Outputs are registered from the next-state decode, so
// vvalid/hvalid/dout/frame_done always describe the cycle in which they appear.
`timescale 1ns/1ps
module video_pattern_gen #(
  parameter int DW       = 8,
  parameter int H_ACTIVE = 1920,
  parameter int H_BLANK  = 280,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_BP     = 36
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   en,
  input  logic [1:0]             pattern_sel,
  input  logic [DW-1:0]          const_val,
  video_pattern_gen_if.master    vid
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_MAX0  = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX   = (V_MAX0 > V_BP) ? V_MAX0 : V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int LW      = $clog2(V_MAX + 1);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
  localparam logic [LW-1:0] VFP_LAST    = LW'(V_FP - 1);
  localparam logic [LW-1:0] VACT_LAST   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VBP_LAST    = LW'(V_BP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VFP,
    ST_LEAD,
    ST_ACTIVE,
    ST_VBP
  } state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [LW-1:0] lcnt_reg, lcnt_next;

  logic [1:0]    sel_reg;
  logic [DW-1:0] const_reg;

  logic          vvalid_reg, hvalid_reg, frame_done_reg;
  logic [DW-1:0] dout_reg;

  logic          vvalid_next, hvalid_next, frame_done_next;
  logic [DW-1:0] dout_next;
  logic          frame_start;
  logic          y_bit3;

  // Raster position and FSM state register; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= ST_IDLE;
      hcnt_reg  <= '0;
      lcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hcnt_reg  <= hcnt_next;
      lcnt_reg  <= lcnt_next;
    end
  end

  // Next-state / counter logic: state moves only at the end of a line (IDLE excepted)
  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    lcnt_next  = lcnt_reg;
    if (state_reg == ST_IDLE) begin
      hcnt_next = '0;
      lcnt_next = '0;
      if (en) state_next = ST_VFP;
    end else if (hcnt_reg != H_LAST) begin
      hcnt_next = hcnt_reg + 1'b1;
    end else begin
      hcnt_next = '0;
      lcnt_next = lcnt_reg + 1'b1;
      case (state_reg)
        ST_VFP: begin
          if (lcnt_reg == VFP_LAST) begin
            state_next = ST_LEAD;
            lcnt_next  = '0;
          end
        end
        ST_LEAD: begin
          state_next = ST_ACTIVE;
          lcnt_next  = '0;
        end
        ST_ACTIVE: begin
          if (lcnt_reg == VACT_LAST) begin
            state_next = ST_VBP;
            lcnt_next  = '0;
          end
        end
        ST_VBP: begin
          if (lcnt_reg == VBP_LAST) begin
            state_next = en ? ST_VFP : ST_IDLE;
            lcnt_next  = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          lcnt_next  = '0;
        end
      endcase
    end
  end

  // A new frame starts whenever VFP is entered from IDLE or from the previous VBP
  assign frame_start = (state_next == ST_VFP) && (state_reg != ST_VFP);

  // Checker needs bit 3 of the line number; short line counters never reach it
  generate
    if (LW > 3) begin : g_ybit
      assign y_bit3 = lcnt_next[3];
    end else begin : g_nobit
      assign y_bit3 = 1'b0;
    end
  endgenerate

  // Pattern selection is frozen for the whole frame
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sel_reg   <= '0;
      const_reg <= '0;
    end else if (frame_start) begin
      sel_reg   <= pattern_sel;
      const_reg <= const_val;
    end
  end

  // Output decode for the position the counters move to this edge
  always_comb begin
    vvalid_next     = (state_next == ST_LEAD) || (state_next == ST_ACTIVE);
    hvalid_next     = (state_next == ST_ACTIVE) && (hcnt_next < H_ACT);
    frame_done_next = (state_next == ST_VBP) && (hcnt_next == H_LAST) &&
                      (lcnt_next == VBP_LAST);
    dout_next       = '0;
    if (hvalid_next) begin
      case (sel_reg)
        2'd0:    dout_next = DW'(hcnt_next);
        2'd1:    dout_next = DW'(lcnt_next);
        2'd2:    dout_next = (hcnt_next[3] ^ y_bit3) ? {DW{1'b1}} : '0;
        default: dout_next = const_reg;
      endcase
    end
  end

  // Registered video outputs, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vvalid_reg     <= 1'b0;
      hvalid_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      dout_reg       <= '0;
    end else begin
      vvalid_reg     <= vvalid_next;
      hvalid_reg     <= hvalid_next;
      frame_done_reg <= frame_done_next;
      dout_reg       <= dout_next;
    end
  end

  assign vid.vvalid     = vvalid_reg;
  assign vid.hvalid     = hvalid_reg;
  assign vid.dout       = dout_reg;
  assign vid.frame_done = frame_done_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a raster model derived from frame timing pushes
// the expected per-cycle outputs of each frame into a scoreboard queue, which
// is popped and compared every cycle on the falling clock edge.
`timescale 1ns/1ps
module tb_video_pattern_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_BLANK  = 4;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_BP     = 2;

  typedef struct packed {
    logic       vv;
    logic       hv;
    logic [7:0] d;
    logic       fd;
  } vid_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] const_val = 8'd0;

  int   checks = 0;
  int   failures = 0;
  vid_t sb_q[$];
  vid_t obs8, obs16;

  video_pattern_gen_if #(.DW(8)) vif8 ();
  video_pattern_gen_if #(.DW(8)) vif16 ();

  video_pattern_gen #(
    .DW(8), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .pattern_sel(pattern_sel),
    .const_val(const_val), .vid(vif8)
  );

  video_pattern_gen #(
    .DW(8), .H_ACTIVE(16), .H_BLANK(H_BLANK),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_BP(V_BP)
  ) dut16 (
    .clk(clk), .rst_b(rst_b), .en(en), .pattern_sel(pattern_sel),
    .const_val(const_val), .vid(vif16)
  );

  assign obs8  = {vif8.vvalid, vif8.hvalid, vif8.dout, vif8.frame_done};
  assign obs16 = {vif16.vvalid, vif16.hvalid, vif16.dout, vif16.frame_done};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Expected outputs at cycle t after frame start T0, from line/pixel position
  function automatic vid_t model(input int t, input int ha, input int sel, input logic [7:0] cv);
    int ht;
    int line;
    int h;
    int y;
    vid_t e;
    ht   = ha + H_BLANK;
    line = t / ht;
    h    = t % ht;
    e    = '0;
    e.vv = (line >= V_FP) && (line <= V_FP + V_ACTIVE);
    if (line >= V_FP + 1 && line <= V_FP + V_ACTIVE && h < ha) begin
      e.hv = 1'b1;
      y = line - V_FP - 1;
      case (sel)
        0:       e.d = h[7:0];
        1:       e.d = y[7:0];
        2:       e.d = ((((h >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
        default: e.d = cv;
      endcase
    end
    e.fd = (t == (V_FP + 1 + V_ACTIVE + V_BP) * ht - 1);
    return e;
  endfunction

  task automatic push_frame(input int ha, input int sel, input logic [7:0] cv);
    int flen;
    flen = (V_FP + 1 + V_ACTIVE + V_BP) * (ha + H_BLANK);
    for (int t = 0; t < flen; t++) sb_q.push_back(model(t, ha, sel, cv));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back('0);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    vid_t exp;
    int   n;
    rst_b = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs8 !== '0) begin failures++; $display("FAIL reset_dut8 got=%h exp=0", obs8); end
    checks++;
    if (obs16 !== '0) begin failures++; $display("FAIL reset_dut16 got=%h exp=0", obs16); end
    en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs8 !== '0) begin failures++; $display("FAIL reset_hold_en got=%h exp=0", obs8); end
    en = 1'b0; rst_b = 1'b1;
    push_idle(4);
    n = sb_q.size();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (obs8 !== exp) begin failures++; $display("FAIL reset_idle t=%0d got=%h exp=%h", t, obs8, exp); end
    end
  endtask

  task automatic test_h_ramp();
    vid_t exp;
    int   n, hv_cnt, vv_cnt, fd_cnt;
    hv_cnt = 0; vv_cnt = 0; fd_cnt = 0;
    pattern_sel = 2'd0; en = 1'b1;
    push_frame(H_ACTIVE, 0, 8'h00);
    push_idle(12);
    n = sb_q.size();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (obs8 !== exp) begin
        failures++;
        $display("FAIL h_ramp t=%0d got vv=%b hv=%b d=%02h fd=%b exp vv=%b hv=%b d=%02h fd=%b",
                 t, obs8.vv, obs8.hv, obs8.d, obs8.fd, exp.vv, exp.hv, exp.d, exp.fd);
      end
      if (obs8.hv === 1'b1) hv_cnt++;
      if (obs8.vv === 1'b1) vv_cnt++;
      if (obs8.fd === 1'b1) fd_cnt++;
      if (t == 50) en = 1'b0;
    end
    checks++;
    if (hv_cnt != H_ACTIVE * V_ACTIVE) begin failures++; $display("FAIL h_ramp_hv_count got=%0d exp=%0d", hv_cnt, H_ACTIVE * V_ACTIVE); end
    checks++;
    if (vv_cnt != (V_ACTIVE + 1) * (H_ACTIVE + H_BLANK)) begin failures++; $display("FAIL h_ramp_vv_count got=%0d exp=%0d", vv_cnt, (V_ACTIVE + 1) * (H_ACTIVE + H_BLANK)); end
    checks++;
    if (fd_cnt != 1) begin failures++; $display("FAIL h_ramp_fd_count got=%0d exp=1", fd_cnt); end
  endtask

  task automatic test_back_to_back();
    vid_t exp;
    int   n;
    pattern_sel = 2'd1; const_val = 8'h00; en = 1'b1;
    push_frame(H_ACTIVE, 1, 8'h00);
    push_frame(H_ACTIVE, 3, 8'hA5);
    push_idle(12);
    n = sb_q.size();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (obs8 !== exp) begin
        failures++;
        $display("FAIL back_to_back t=%0d got vv=%b hv=%b d=%02h fd=%b exp vv=%b hv=%b d=%02h fd=%b",
                 t, obs8.vv, obs8.hv, obs8.d, obs8.fd, exp.vv, exp.hv, exp.d, exp.fd);
      end
      if (t == 40) begin pattern_sel = 2'd3; const_val = 8'hA5; end
      if (t == 108 + 40) const_val = 8'h3C;
      if (t == 108 + 50) en = 1'b0;
    end
  endtask

  task automatic test_checker();
    vid_t exp;
    int   n;
    do_reset();
    pattern_sel = 2'd2; en = 1'b1;
    push_frame(16, 2, 8'h00);
    push_idle(10);
    n = sb_q.size();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (obs16 !== exp) begin
        failures++;
        $display("FAIL checker t=%0d got vv=%b hv=%b d=%02h fd=%b exp vv=%b hv=%b d=%02h fd=%b",
                 t, obs16.vv, obs16.hv, obs16.d, obs16.fd, exp.vv, exp.hv, exp.d, exp.fd);
      end
      if (t == 50) en = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    vid_t exp;
    int   n;
    pattern_sel = 2'd0; en = 1'b1;
    push_frame(H_ACTIVE, 0, 8'h00);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (obs8 !== exp) begin failures++; $display("FAIL mid_reset_pre t=%0d got=%h exp=%h", t, obs8, exp); end
    end
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    if (obs8 !== exp) begin failures++; $display("FAIL mid_reset_burst got=%h exp=%h", obs8, exp); end
    rst_b = 1'b0;
    #1;
    checks++;
    if (obs8 !== '0) begin failures++; $display("FAIL mid_reset_async got=%h exp=0", obs8); end
    checks++;
    if (obs16 !== '0) begin failures++; $display("FAIL mid_reset_async16 got=%h exp=0", obs16); end
    sb_q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (obs8 !== '0) begin failures++; $display("FAIL mid_reset_hold got=%h exp=0", obs8); end
    rst_b = 1'b1;
    push_frame(H_ACTIVE, 0, 8'h00);
    push_idle(12);
    n = sb_q.size();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      checks++;
      if (obs8 !== exp) begin
        failures++;
        $display("FAIL mid_reset_restart t=%0d got vv=%b hv=%b d=%02h fd=%b exp vv=%b hv=%b d=%02h fd=%b",
                 t, obs8.vv, obs8.hv, obs8.d, obs8.fd, exp.vv, exp.hv, exp.d, exp.fd);
      end
      if (t == 50) en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_h_ramp();
    test_back_to_back();
    test_checker();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
